// File: rtl/mem_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ram_ctrl
// Brief    : Single-port word memory behind a req/done handshake with optional
//            wait states, per-byte write enables and out-of-range flagging.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ram_ctrl #(
    parameter int    DATA_WIDTH  = 32,
    parameter int    ADDR_WIDTH  = 32,
    parameter int    DEPTH       = 512,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      done,
    output logic                      busy,
    output logic                      addr_err
);

    localparam int                    c_LANES     = DATA_WIDTH / 8;
    localparam int                    c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]            c_WAIT      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_we;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [c_LANES-1:0]       r_ben;
    logic [3:0]               r_cnt;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_done;
    logic                     r_addr_err;
    logic [DATA_WIDTH-1:0]    r_mem [0:DEPTH-1];

    logic                     w_accept;
    logic                     w_access;
    logic                     w_in_range;
    logic [c_IDX_W-1:0]       w_idx;

    assign w_accept   = (r_state == S_IDLE) && req;
    assign w_access   = (r_state == S_ACCESS);
    // Full-width compare so high address bits can never alias into the array
    assign w_in_range = ({1'b0, r_addr} < c_DEPTH_EXT);
    assign w_idx      = r_addr[c_IDX_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next = (c_WAIT != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ben      <= '0;
            r_cnt      <= 4'd0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_done <= w_access;
            if (w_accept) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_ben   <= byte_en;
                r_cnt   <= c_WAIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_addr_err <= !w_in_range;
                if (!r_we) begin
                    r_rdata <= w_in_range ? r_mem[w_idx] : '0;
                end
            end
        end
    end

    // Array is deliberately outside the reset domain: contents survive reset
    always_ff @(posedge clock) begin
        if (w_access && r_we && w_in_range) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (r_ben[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata    = r_rdata;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE);
    assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ram_ctrl
// Brief    : Self-checking bench for mem_ram_ctrl with zero and three wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  ben   [2];
    logic [31:0] rdata [2];
    logic        done  [2];
    logic        busy  [2];
    logic        aerr  [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] mem_m   [2][0:511];
    logic [31:0] last_rd [2];

    mem_ram_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .clock(clk), .reset_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .byte_en(ben[0]), .rdata(rdata[0]), .done(done[0]),
        .busy(busy[0]), .addr_err(aerr[0])
    );

    mem_ram_ctrl #(.WAIT_STATES(3)) u_dut1 (
        .clock(clk), .reset_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .byte_en(ben[1]), .rdata(rdata[1]), .done(done[1]),
        .busy(busy[1]), .addr_err(aerr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference behaviour: lane-merged writes, zero data and error flag out of range
    function automatic void model_step(input int d, input bit w, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [3:0] be,
                                       output logic [31:0] erd, output logic eerr);
        eerr = (a >= 32'd512);
        if (w) begin
            if (!eerr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[d][a[8:0]][8*b +: 8] = wd[8*b +: 8];
                end
            end
            erd = last_rd[d];
        end else begin
            erd = eerr ? 32'h0 : mem_m[d][a[8:0]];
            last_rd[d] = erd;
        end
    endfunction

    // Drives one request, scrambles inputs after acceptance, waits (bounded) for done
    task automatic access(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output int lat, output int bc,
                          output logic err);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; ben[d] = be;
        @(posedge clk); #1;
        req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom;
        wdata[d] = $urandom; ben[d] = 4'($urandom);
        lat = 0;
        bc  = 0;
        while (done[d] !== 1'b1 && lat < 40) begin
            if (busy[d] === 1'b1) bc++;
            @(posedge clk); #1;
            lat++;
        end
        rd  = rdata[d];
        err = aerr[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (rdata[d] !== 32'h0) begin n_err++; $display("FAIL reset_rdata dut%0d: got %h expected 0", d, rdata[d]); end
            n_cmp++; if (done[d] !== 1'b0) begin n_err++; $display("FAIL reset_done dut%0d: got %b expected 0", d, done[d]); end
            n_cmp++; if (busy[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d: got %b expected 0", d, busy[d]); end
            n_cmp++; if (aerr[d] !== 1'b0) begin n_err++; $display("FAIL reset_addr_err dut%0d: got %b expected 0", d, aerr[d]); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; int lat, bc; logic err;
        access(0, 1'b1, 32'd133, 32'd16, 4'hF, rd, lat, bc, err);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL basic_wr_latency: got %0d expected 1", lat); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL basic_wr_err: got %b expected 0", err); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL basic_wr_rdata_hold: got %h expected 0", rd); end
        access(0, 1'b0, 32'd133, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL basic_rd_latency: got %0d expected 1", lat); end
        n_cmp++; if (rd !== 32'h0000_0010) begin n_err++; $display("FAIL basic_rd_data: got %h expected 00000010", rd); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL basic_rd_err: got %b expected 0", err); end
    endtask

    task automatic test_wait();
        logic [31:0] rd; int lat, bc; logic err;
        access(1, 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, rd, lat, bc, err);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL wait_wr_latency: got %0d expected 4", lat); end
        access(1, 1'b0, 32'd5, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL wait_rd_latency: got %0d expected 4", lat); end
        n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL wait_busy_cycles: got %0d expected 4", bc); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wait_rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] rd; int lat, bc; logic err;
        int dones = 0;
        access(1, 1'b1, 32'd133, 32'h0000_0A0A, 4'hF, rd, lat, bc, err);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd5; ben[1] = 4'h0;
        @(posedge clk); #1 req[1] = 1'b0;
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd133; wdata[1] = 32'hFFFF_FFFF; ben[1] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1 req[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done[1] === 1'b1) dones++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL busy_ignore_dones: got %0d expected 1", dones); end
        access(1, 1'b0, 32'd133, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h0000_0A0A) begin n_err++; $display("FAIL busy_ignore_mem: got %h expected 00000a0a", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int lat, bc; logic err;
        access(0, 1'b1, 32'd90, 32'h1122_3344, 4'hF, rd, lat, bc, err);
        access(0, 1'b1, 32'd90, 32'hAABB_CCDD, 4'b0101, rd, lat, bc, err);
        access(0, 1'b0, 32'd90, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h11BB_33DD) begin n_err++; $display("FAIL lanes_merge: got %h expected 11bb33dd", rd); end
        access(0, 1'b1, 32'd90, 32'h0000_0000, 4'h0, rd, lat, bc, err);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL lanes_zero_be_done: got latency %0d expected 1", lat); end
        access(0, 1'b0, 32'd90, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h11BB_33DD) begin n_err++; $display("FAIL lanes_zero_be_mem: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; int lat, bc; logic err;
        access(0, 1'b1, 32'd88, 32'h0BAD_F00D, 4'hF, rd, lat, bc, err);
        access(0, 1'b1, 32'd600, 32'hFFFF_FFFF, 4'hF, rd, lat, bc, err);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL oor_wr_err: got %b expected 1", err); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL oor_wr_latency: got %0d expected 1", lat); end
        access(0, 1'b0, 32'd600, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL oor_rd_err: got %b expected 1", err); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL oor_rd_data: got %h expected 0", rd); end
        access(0, 1'b0, 32'd88, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_err++; $display("FAIL oor_alias: got %h expected 0badf00d", rd); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL oor_clear_err: got %b expected 0", err); end
        access(0, 1'b1, 32'd511, 32'h1234_5678, 4'hF, rd, lat, bc, err);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL oor_last_valid: got %b expected 0", err); end
        access(0, 1'b1, 32'd512, 32'h0, 4'hF, rd, lat, bc, err);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL oor_first_invalid: got %b expected 1", err); end
        access(0, 1'b1, 32'h8000_0058, 32'hCAFE_CAFE, 4'hF, rd, lat, bc, err);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL oor_high_bit_err: got %b expected 1", err); end
        access(0, 1'b0, 32'd88, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_err++; $display("FAIL oor_high_bit_alias: got %h expected 0badf00d", rd); end
        access(0, 1'b0, 32'd511, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL oor_last_data: got %h expected 12345678", rd); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; int lat, bc; logic err;
        access(0, 1'b0, 32'd133, 32'h0, 4'h0, rd, lat, bc, err);
        access(0, 1'b1, 32'd600, 32'h0, 4'hF, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h10 || err !== 1'b1) begin n_err++; $display("FAIL async_pre: got rdata %h err %b expected 00000010 1", rd, err); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (done[0] !== 1'b0) begin n_err++; $display("FAIL async_done: got %b expected 0", done[0]); end
        n_cmp++; if (rdata[0] !== 32'h0) begin n_err++; $display("FAIL async_rdata: got %h expected 0", rdata[0]); end
        n_cmp++; if (aerr[0] !== 1'b0) begin n_err++; $display("FAIL async_addr_err: got %b expected 0", aerr[0]); end
        @(posedge clk); #1 rst_n = 1'b1;
        access(0, 1'b0, 32'd133, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h10) begin n_err++; $display("FAIL async_mem_kept: got %h expected 00000010", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat, bc; logic err;
        int dones = 0;
        access(1, 1'b1, 32'd175, 32'h1111_2222, 4'hF, rd, lat, bc, err);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd175; wdata[1] = 32'h55; ben[1] = 4'hF;
        @(posedge clk); #1 req[1] = 1'b0;
        repeat (2) begin
            if (done[1] === 1'b1) dones++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy[1] !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy[1]); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done[1] === 1'b1) dones++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL abort_dones: got %0d expected 0", dones); end
        access(1, 1'b0, 32'd175, 32'h0, 4'h0, rd, lat, bc, err);
        n_cmp++; if (rd !== 32'h1111_2222) begin n_err++; $display("FAIL abort_mem_kept: got %h expected 11112222", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat, bc; logic err;
        int t0, need;
        for (int d = 0; d < 2; d++) begin
            t0 = cyc;
            for (int k = 0; k < 5; k++) access(d, 1'b0, 32'd133, 32'h0, 4'h0, rd, lat, bc, err);
            need = 5 * (wait_of(d) + 2);
            n_cmp++; if (cyc - t0 !== need) begin n_err++; $display("FAIL b2b_cycles dut%0d: got %0d expected %0d", d, cyc - t0, need); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd; int lat, bc; logic err, eerr; bit w; logic [3:0] be;
        int d, r;
        for (int dd = 0; dd < 2; dd++) begin
            for (int p = 0; p < 24; p++) begin
                a  = (p < 16) ? 32'(p) : 32'(504 + p - 16);
                wd = $urandom;
                model_step(dd, 1'b1, a, wd, 4'hF, erd, eerr);
                access(dd, 1'b1, a, wd, 4'hF, rd, lat, bc, err);
            end
            model_step(dd, 1'b0, 32'd0, 32'h0, 4'h0, erd, eerr);
            access(dd, 1'b0, 32'd0, 32'h0, 4'h0, rd, lat, bc, err);
            n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL rand_init dut%0d: got %h expected %h", dd, rd, erd); end
        end
        for (int k = 0; k < 80; k++) begin
            d  = int'($urandom_range(0, 1));
            w  = 1'($urandom);
            wd = $urandom;
            be = 4'($urandom);
            r  = int'($urandom_range(0, 29));
            if (r < 16)      a = 32'(r);
            else if (r < 24) a = 32'(504 + r - 16);
            else if (r < 27) a = 32'(512 + $urandom_range(0, 300));
            else             a = {1'b1, 31'($urandom)};
            model_step(d, w, a, wd, be, erd, eerr);
            access(d, w, a, wd, be, rd, lat, bc, err);
            n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL rand_rdata dut%0d op%0d addr %h: got %h expected %h", d, k, a, rd, erd); end
            n_cmp++; if (err !== eerr) begin n_err++; $display("FAIL rand_addr_err dut%0d op%0d addr %h: got %b expected %b", d, k, a, err, eerr); end
            n_cmp++; if (lat !== wait_of(d) + 1) begin n_err++; $display("FAIL rand_latency dut%0d op%0d: got %0d expected %0d", d, k, lat, wait_of(d) + 1); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; ben[d] = '0;
            last_rd[d] = '0;
        end
        test_reset();
        test_basic();
        test_wait();
        test_busy_ignore();
        test_byte_lanes();
        test_out_of_range();
        test_async_reset();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
